adc_conv_sequencer: RTL and testbench
=====================================

ADC_CONV_SEQUENCER -- requirements
Module: adc_conv_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).
REQ-002 Parameter: TIMEOUT_CYCLES, 1023, max cycles waiting for conversion end.
REQ-003 Parameter: START_PULSE_CYCLES, 2, width of start strobe to ADC.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- enable_in  in  1  continuous conversion mode while high.
- trig_in  in  1  single-shot request pulse, honoured in IDLE only.
- period_in  in  16  idle cycles between capture and next start (continuous mode).
- config_1_in, config_2_in  in  16 each  host ADC configuration words.
- clear_flags_in  in  1  clears sticky flags.
- adc_config_1_out, adc_config_2_out  out  16 each  configuration words driven to the ADC.
- adc_start_conversion_out  out  1  start strobe to the ADC.
- adc_conversion_finished_in  in  1  one-cycle ADC done strobe.
- adc_result_in  in  16  ADC result, valid with done strobe.
- rd_en_in  in  1  FIFO pop.
- rd_data_out  out  16  FIFO head (show-ahead).
- fifo_empty_out, fifo_full_out  out  1 each  FIFO status.
- fifo_level_out  out  clog2(FIFO_DEPTH)+1  entries held.
- busy_out  out  1  high in any state except IDLE.
- overflow_out, timeout_out  out  1 each  sticky error flags.
REQ-005 Clock/reset decision: one clock; reset is synchronous and active-high.

Function
REQ-006 FSM states: IDLE, START, WAIT, CAPTURE, HOLDOFF.
REQ-007 IDLE -> START at the edge where enable_in=1 or trig_in=1; config_1_in/config_2_in latched into adc_config_*_out on that edge and held constant until next IDLE->START or HOLDOFF->START.
REQ-008 START: adc_start_conversion_out=1 for exactly START_PULSE_CYCLES cycles, then WAIT.
REQ-009 adc_conversion_finished_in is ignored outside WAIT.
REQ-010 WAIT: on edge sampling done strobe high, register adc_result_in, go CAPTURE; timeout counter cleared on entry to WAIT.
REQ-011 WAIT: counter reaching TIMEOUT_CYCLES without strobe sets timeout_out, nothing written, go HOLDOFF.
REQ-012 CAPTURE (one cycle): push registered result; fifo_empty_out falls on the edge ending CAPTURE; then HOLDOFF.
REQ-013 HOLDOFF: lasts period_in cycles (period_in=0 -> zero cycles); at end, START if enable_in=1 else IDLE; config relatched on HOLDOFF->START.
REQ-014 enable_in dropping mid-conversion: current conversion completes and is captured, then IDLE; trig_in outside IDLE ignored.
REQ-015 Push when full: data dropped, FIFO unchanged, overflow_out set.
REQ-016 Pop when empty: ignored, no pointer change.
REQ-017 Simultaneous push and pop: both occur, level unchanged; when full, pop frees the slot and the push is accepted (no overflow).
REQ-018 Pointers wrap modulo FIFO_DEPTH; level = 0..FIFO_DEPTH; fifo_full_out = (level==FIFO_DEPTH).
REQ-019 clear_flags_in clears overflow_out/timeout_out; a simultaneous set event wins.

Reset
REQ-020 rst high: state IDLE, all counters 0, FIFO empty, adc_start_conversion_out=0, adc_config_*_out=16'h0000, rd_data_out=16'h0000, busy/overflow/timeout=0, fifo_empty_out=1, fifo_full_out=0, fifo_level_out=0.
REQ-021 rst mid-conversion aborts immediately; any later done strobe is ignored unless in WAIT.

Structure
REQ-022 State encoding and default parameter values in shared package adc_pkg.
REQ-023 FIFO implemented as sub-module adc_result_fifo (push/pop/full/empty/level); FSM and counters in top.

Verification
REQ-024 trig_in pulse, enable_in=0, ADC model returns 16'h0ABC 10 cycles after start -> start high 2 cycles, rd_data_out=16'h0ABC, level=1, FSM returns to IDLE.
REQ-025 enable_in=1, period_in=5, no reads -> 4 results stored, 5th dropped, overflow_out=1, fifo_full_out=1; start-to-start spacing consistent with 5-cycle HOLDOFF.
REQ-026 ADC model never responds, TIMEOUT_CYCLES=1023 -> timeout_out=1 after 1023 WAIT cycles, FIFO empty, next start issued in continuous mode.
REQ-027 FIFO full, rd_en_in asserted in CAPTURE cycle -> level stays 4, overflow_out stays 0, head advances.
REQ-028 rst asserted during WAIT, done strobe 1 cycle after release -> strobe ignored, FIFO empty, all outputs at reset values.
REQ-029 config words changed during WAIT -> adc_config_*_out unchanged until next START.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion sequencer: FSM state encoding,
// default parameter values and the internal counter width.
package adc_pkg;

    localparam int unsigned DEF_FIFO_DEPTH         = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES     = 1023;
    localparam int unsigned DEF_START_PULSE_CYCLES = 2;
    localparam int unsigned CNT_W                  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_HOLDOFF
    } state_e;

endpackage

// File: rtl/adc_result_fifo.sv
// Show-ahead result FIFO with level tracking; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module adc_result_fifo
    import adc_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [15:0]   push_data_i,
    input  logic          pop_i,
    output logic [15:0]   head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o,
    output logic          overflow_o
);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (level_q != '0);
        do_push  = push_i && ((level_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head reads as zero while empty so stale storage never leaks out.
    assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];
    assign empty_o    = (level_q == '0);
    assign full_o     = (level_q == (AW+1)'(DEPTH));
    assign level_o    = level_q;
    assign overflow_o = push_i && !do_push;

endmodule

// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: issues start strobes, waits for the done strobe
// with a timeout, captures results into a FIFO and paces continuous mode.
module adc_conv_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH         = DEF_FIFO_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
    parameter int unsigned START_PULSE_CYCLES = DEF_START_PULSE_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable_in,
    input  logic                          trig_in,
    input  logic [15:0]                   period_in,
    input  logic [15:0]                   config_1_in,
    input  logic [15:0]                   config_2_in,
    input  logic                          clear_flags_in,
    output logic [15:0]                   adc_config_1_out,
    output logic [15:0]                   adc_config_2_out,
    output logic                          adc_start_conversion_out,
    input  logic                          adc_conversion_finished_in,
    input  logic [15:0]                   adc_result_in,
    input  logic                          rd_en_in,
    output logic [15:0]                   rd_data_out,
    output logic                          fifo_empty_out,
    output logic                          fifo_full_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          busy_out,
    output logic                          overflow_out,
    output logic                          timeout_out
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      cfg1_q, cfg1_d, cfg2_q, cfg2_d;
    logic [15:0]      result_q, result_d;
    logic             ovf_q, ovf_d, tmo_q, tmo_d;
    logic             push, tmo_set, leave_conv, holdoff_done, fifo_ovf;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        cfg1_d       = cfg1_q;
        cfg2_d       = cfg2_q;
        result_d     = result_q;
        push         = 1'b0;
        tmo_set      = 1'b0;
        leave_conv   = 1'b0;
        holdoff_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable_in || trig_in) begin
                    state_d = ST_START;
                    cfg1_d  = config_1_in;
                    cfg2_d  = config_2_in;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_W'(START_PULSE_CYCLES - 1)) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (adc_conversion_finished_in) begin
                    result_d = adc_result_in;
                    state_d  = ST_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_set    = 1'b1;
                    leave_conv = 1'b1;
                end
            end
            ST_CAPTURE: begin
                push       = 1'b1;
                leave_conv = 1'b1;
            end
            ST_HOLDOFF: begin
                // Range compare tolerates period_in shrinking mid-holdoff.
                holdoff_done = ({1'b0, cnt_q} + 17'd1) >= {1'b0, period_in};
            end
            default: state_d = ST_IDLE;
        endcase

        // A zero period skips HOLDOFF entirely and decides START/IDLE at once.
        if (leave_conv && (period_in != '0)) begin
            state_d = ST_HOLDOFF;
            cnt_d   = '0;
        end else if (leave_conv || holdoff_done) begin
            cnt_d = '0;
            if (enable_in) begin
                state_d = ST_START;
                cfg1_d  = config_1_in;
                cfg2_d  = config_2_in;
            end else begin
                state_d = ST_IDLE;
            end
        end

        ovf_d = fifo_ovf | (ovf_q & ~clear_flags_in);
        tmo_d = tmo_set  | (tmo_q & ~clear_flags_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cfg1_q   <= '0;
            cfg2_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg1_q   <= cfg1_d;
            cfg2_q   <= cfg2_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    adc_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (result_q),
        .pop_i       (rd_en_in),
        .head_o      (rd_data_out),
        .empty_o     (fifo_empty_out),
        .full_o      (fifo_full_out),
        .level_o     (fifo_level_out),
        .overflow_o  (fifo_ovf)
    );

    assign adc_config_1_out         = cfg1_q;
    assign adc_config_2_out         = cfg2_q;
    assign adc_start_conversion_out = (state_q == ST_START);
    assign busy_out                 = (state_q != ST_IDLE);
    assign overflow_out             = ovf_q;
    assign timeout_out              = tmo_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Scoreboard bench for adc_conv_sequencer: an ADC model feeds results, a
// queue-based reference FIFO predicts contents and flags, a monitor compares.
module tb_adc_conv_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 1023;
    localparam int SPW   = 2;

    logic        clk;
    logic        rst;
    logic        enable_in, trig_in, clear_flags_in, rd_en_in;
    logic [15:0] period_in, config_1_in, config_2_in;
    logic [15:0] adc_config_1_out, adc_config_2_out;
    logic        adc_start_conversion_out;
    logic        adc_done;
    logic [15:0] adc_result;
    logic [15:0] rd_data_out;
    logic        fifo_empty_out, fifo_full_out;
    logic [2:0]  fifo_level_out;
    logic        busy_out, overflow_out, timeout_out;

    adc_conv_sequencer #(
        .FIFO_DEPTH         (DEPTH),
        .TIMEOUT_CYCLES     (TMO),
        .START_PULSE_CYCLES (SPW)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .enable_in                  (enable_in),
        .trig_in                    (trig_in),
        .period_in                  (period_in),
        .config_1_in                (config_1_in),
        .config_2_in                (config_2_in),
        .clear_flags_in             (clear_flags_in),
        .adc_config_1_out           (adc_config_1_out),
        .adc_config_2_out           (adc_config_2_out),
        .adc_start_conversion_out   (adc_start_conversion_out),
        .adc_conversion_finished_in (adc_done),
        .adc_result_in              (adc_result),
        .rd_en_in                   (rd_en_in),
        .rd_data_out                (rd_data_out),
        .fifo_empty_out             (fifo_empty_out),
        .fifo_full_out              (fifo_full_out),
        .fifo_level_out             (fifo_level_out),
        .busy_out                   (busy_out),
        .overflow_out               (overflow_out),
        .timeout_out                (timeout_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state (updated on every rising edge from driven inputs)
    logic [15:0] exp_q[$];
    bit          exp_ovf = 1'b0, exp_tmo = 1'b0, push_pend = 1'b0;
    logic [15:0] pend_data = '0;
    int          cyc = 0;
    logic [15:0] cfg1_at_edge = '0, cfg2_at_edge = '0;

    // ADC model and test controls
    bit          cap_evt = 1'b0, tmo_evt = 1'b0, spur_req = 1'b0;
    bit          outstanding = 1'b0, never_cur = 1'b0, start_prev = 1'b0;
    int          age = 0, dly_cur = 0, hi_cnt = 0;
    int          n_starts = 0, n_results = 0, last_rise = 0, cap_cycle = -1;
    logic [15:0] data_cur = '0, exp_c1 = '0, exp_c2 = '0;
    bit          adc_fixed = 1'b1, adc_never = 1'b0, rand_never = 1'b0;
    int          adc_fix_delay = 10;
    logic [15:0] adc_fix_data = 16'h0ABC;
    bit          chk_spacing = 1'b0, sp_armed = 1'b0, mon_en = 1'b0;
    int          exp_spacing = 0;

    // Reference FIFO: pop before push, so a full FIFO with a pop takes the push.
    initial forever begin
        @(posedge clk);
        cyc++;
        cfg1_at_edge = config_1_in;
        cfg2_at_edge = config_2_in;
        if (rst) begin
            exp_q.delete();
            exp_ovf   = 1'b0;
            exp_tmo   = 1'b0;
            push_pend = 1'b0;
        end else begin
            if (clear_flags_in) begin
                exp_ovf = 1'b0;
                exp_tmo = 1'b0;
            end
            if (rd_en_in && exp_q.size() > 0) void'(exp_q.pop_front());
            if (push_pend) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(pend_data);
                else exp_ovf = 1'b1;
            end
            push_pend = 1'b0;
            if (adc_done && cap_evt) begin
                push_pend = 1'b1;
                pend_data = adc_result;
            end
            if (tmo_evt) exp_tmo = 1'b1;
        end
    end

    // ADC model: answers each start after a delay (or never), drives spurious strobes on request.
    initial begin
        adc_done   = 1'b0;
        adc_result = '0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            cap_evt  = 1'b0;
            tmo_evt  = 1'b0;
            if (rst) begin
                outstanding = 1'b0;
                start_prev  = 1'b0;
                hi_cnt      = 0;
            end else begin
                if (adc_start_conversion_out) begin
                    if (!start_prev) begin
                        n_starts++;
                        if (chk_spacing && sp_armed) chk("start_spacing", cyc - last_rise, exp_spacing);
                        sp_armed    = 1'b1;
                        last_rise   = cyc;
                        outstanding = 1'b1;
                        age         = 0;
                        exp_c1      = cfg1_at_edge;
                        exp_c2      = cfg2_at_edge;
                        chk("cfg1_at_start", 32'(adc_config_1_out), 32'(exp_c1));
                        chk("cfg2_at_start", 32'(adc_config_2_out), 32'(exp_c2));
                        never_cur = adc_never || (!adc_fixed && rand_never && $urandom_range(0, 99) == 0);
                        dly_cur   = adc_fixed ? adc_fix_delay : int'($urandom_range(2, 14));
                        data_cur  = adc_fixed ? adc_fix_data : 16'($urandom);
                    end
                    hi_cnt++;
                end else if (start_prev) begin
                    chk("start_width", hi_cnt, SPW);
                    hi_cnt = 0;
                end
                start_prev = adc_start_conversion_out;
                if (outstanding) begin
                    if (!never_cur && age == dly_cur) begin
                        adc_done    = 1'b1;
                        adc_result  = data_cur;
                        cap_evt     = 1'b1;
                        outstanding = 1'b0;
                        n_results++;
                        cap_cycle = cyc + 1;
                        chk("cfg1_held", 32'(adc_config_1_out), 32'(exp_c1));
                        chk("cfg2_held", 32'(adc_config_2_out), 32'(exp_c2));
                        if (adc_fixed) adc_fix_data = adc_fix_data + 16'd1;
                    end else if (never_cur && age == TMO + 1) begin
                        tmo_evt     = 1'b1;
                        outstanding = 1'b0;
                    end
                    age++;
                end
                if (spur_req) begin
                    adc_done   = 1'b1;
                    adc_result = 16'hDEAD;
                    spur_req   = 1'b0;
                end
            end
        end
    end

    // Monitor: compares FIFO view and sticky flags against the reference every cycle.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("level", 32'(fifo_level_out), exp_q.size());
            chk("empty", 32'(fifo_empty_out), 32'(exp_q.size() == 0));
            chk("full", 32'(fifo_full_out), 32'(exp_q.size() == DEPTH));
            if (exp_q.size() > 0) chk("rd_data", 32'(rd_data_out), 32'(exp_q[0]));
            chk("overflow", 32'(overflow_out), 32'(exp_ovf));
            chk("timeout", 32'(timeout_out), 32'(exp_tmo));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy_out) break;
        end
        chk(name, 32'(busy_out), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start"}, 32'(adc_start_conversion_out), 0);
        chk({tag, "_cfg1"}, 32'(adc_config_1_out), 0);
        chk({tag, "_cfg2"}, 32'(adc_config_2_out), 0);
        chk({tag, "_rd_data"}, 32'(rd_data_out), 0);
        chk({tag, "_busy"}, 32'(busy_out), 0);
        chk({tag, "_ovf"}, 32'(overflow_out), 0);
        chk({tag, "_tmo"}, 32'(timeout_out), 0);
        chk({tag, "_empty"}, 32'(fifo_empty_out), 1);
        chk({tag, "_full"}, 32'(fifo_full_out), 0);
        chk({tag, "_level"}, 32'(fifo_level_out), 0);
    endtask

    int s0, r0, rd_prob;
    int rd_tbl[8] = '{0, 2, 8, 16, 1, 4, 0, 12};

    initial begin
        rst = 1'b1; enable_in = 1'b0; trig_in = 1'b0; clear_flags_in = 1'b0; rd_en_in = 1'b0;
        period_in = 16'd5; config_1_in = 16'h1234; config_2_in = 16'h5678;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_vals("reset");
        mon_en = 1'b1;

        // Single shot: result 0ABC, back to IDLE with one entry.
        s0 = n_starts; r0 = n_results;
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        config_1_in = 16'hAAAA; config_2_in = 16'h5555;
        wait_idle("single_idle", 200);
        chk("single_starts", n_starts - s0, 1);
        chk("single_results", n_results - r0, 1);
        chk("single_data", 32'(rd_data_out), 32'h0ABC);
        chk("single_level", 32'(fifo_level_out), 1);
        rd_en_in = 1'b1; tick(); rd_en_in = 1'b0;

        // Continuous, period 5, no reads: four stored, fifth dropped.
        adc_fix_data = 16'h1000; period_in = 16'd5;
        chk_spacing = 1'b1; sp_armed = 1'b0; exp_spacing = 10 + 2 + 5;
        r0 = n_results;
        enable_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            config_1_in = 16'($urandom); config_2_in = 16'($urandom);
            if (n_results >= r0 + 5) break;
        end
        enable_in = 1'b0;
        chk("cont_results", n_results - r0, 5);
        wait_idle("cont_idle", 100);
        chk_spacing = 1'b0;
        chk("cont_full", 32'(fifo_full_out), 1);
        chk("cont_ovf", 32'(overflow_out), 1);
        chk("cont_level", 32'(fifo_level_out), DEPTH);

        // Full FIFO, pop during CAPTURE: push accepted, no overflow.
        clear_flags_in = 1'b1; tick(); clear_flags_in = 1'b0;
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            rd_en_in = (cyc == cap_cycle);
            if (!busy_out && !rd_en_in) break;
        end
        rd_en_in = 1'b0;
        chk("popcap_busy", 32'(busy_out), 0);
        chk("popcap_level", 32'(fifo_level_out), DEPTH);
        chk("popcap_ovf", 32'(overflow_out), 0);
        chk("popcap_head", 32'(rd_data_out), 32'h1001);
        rd_en_in = 1'b1; repeat (6) tick(); rd_en_in = 1'b0;
        tick();
        chk("drain_empty", 32'(fifo_empty_out), 1);
        chk("drain_level", 32'(fifo_level_out), 0);

        // Timeout in continuous mode, period 3; next start follows.
        adc_never = 1'b1; period_in = 16'd3;
        chk_spacing = 1'b1; sp_armed = 1'b0; exp_spacing = TMO + 2 + 3;
        s0 = n_starts;
        enable_in = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (timeout_out) break;
        end
        chk("tmo_flag", 32'(timeout_out), 1);
        chk("tmo_empty", 32'(fifo_empty_out), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_starts >= s0 + 2) break;
        end
        chk("tmo_restart", n_starts - s0, 2);
        rst = 1'b1; enable_in = 1'b0; tick(); tick(); rst = 1'b0;
        adc_never = 1'b0; chk_spacing = 1'b0;
        tick();
        check_reset_vals("tmo_rst");

        // Reset during WAIT, then a stray done strobe right after release.
        adc_fix_delay = 50;
        config_1_in = 16'hBEEF; config_2_in = 16'hCAFE;
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        repeat (8) tick();
        chk("wait_busy", 32'(busy_out), 1);
        rst = 1'b1; tick();
        rst = 1'b0; spur_req = 1'b1; tick();
        repeat (4) tick();
        check_reset_vals("wait_rst");
        adc_fix_delay = 10;

        // Randomized traffic against the reference model.
        adc_fixed = 1'b0; rand_never = 1'b1;
        for (int blk = 0; blk < 8; blk++) begin
            rd_prob = rd_tbl[blk];
            period_in = 16'($urandom_range(0, 6));
            for (int c = 0; c < 1000; c++) begin
                tick();
                config_1_in    = 16'($urandom);
                config_2_in    = 16'($urandom);
                if ($urandom_range(0, 49) == 0) enable_in = ~enable_in;
                trig_in        = ($urandom_range(0, 14) == 0);
                rd_en_in       = (int'($urandom_range(0, 15)) < rd_prob);
                clear_flags_in = ($urandom_range(0, 39) == 0);
                rst            = ($urandom_range(0, 1499) == 0);
                if ($urandom_range(0, 19) == 0) period_in = 16'($urandom_range(0, 6));
            end
        end
        enable_in = 1'b0; trig_in = 1'b0; rd_en_in = 1'b0; clear_flags_in = 1'b0; rst = 1'b0;
        rand_never = 1'b0;
        wait_idle("final_idle", 2500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
